// File: rtl/mc_control_fsm.sv
// Multi-cycle main controller for the MIPS subset core: sequences fetch/decode/
// execute/memory/write-back, drives Moore datapath controls, counts retired instructions.
module mc_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       RegDst,
  output logic             ALUSrc,
  output logic             ExtOp,
  output logic [2:0]       ALUOp,
  output logic [1:0]       MemToReg,
  output logic [1:0]       NPCSel,
  output logic [3:0]       State,
  output logic             Illegal,
  output logic [CNT_W-1:0] RetCnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_REG   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10
  } state_e;

  typedef enum logic [3:0] {
    C_ADDU, C_SUBU, C_JR, C_NOP, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_JAL, C_ILL
  } cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;
  cls_e             cls;
  logic             r_type;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cls = C_ILL;
    case (Op)
      6'b000000: begin
        case (Func)
          6'b100001: cls = C_ADDU;
          6'b100011: cls = C_SUBU;
          6'b001000: cls = C_JR;
          6'b000000: cls = C_NOP;
          default:   cls = C_ILL;
        endcase
      end
      6'b001101: cls = C_ORI;
      6'b001111: cls = C_LUI;
      6'b100011: cls = C_LW;
      6'b101011: cls = C_SW;
      6'b000100: cls = C_BEQ;
      6'b000011: cls = C_JAL;
      default:   cls = C_ILL;
    endcase
  end

  assign r_type = (cls == C_ADDU) || (cls == C_SUBU);

  always_comb begin
    state_d   = S_FETCH;
    ret_cnt_d = ret_cnt_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (cls)
          C_ADDU, C_SUBU: state_d = S_EXEC_R;
          C_ORI, C_LUI:   state_d = S_EXEC_I;
          C_LW, C_SW:     state_d = S_MEM_ADDR;
          C_BEQ:          state_d = S_BRANCH;
          C_JAL, C_JR:    state_d = S_JUMP;
          C_NOP: begin
            state_d   = S_FETCH;
            ret_cnt_d = ret_cnt_q + CNT_W'(1);
          end
          default:        state_d = S_FETCH;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_WB_REG;
      S_MEM_ADDR: state_d = (cls == C_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_MEM;
      S_WB_REG, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP: begin
        state_d   = S_FETCH;
        ret_cnt_d = ret_cnt_q + CNT_W'(1);
      end
      default:    state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= S_FETCH;
      ret_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    ExtOp    = 1'b0;
    ALUOp    = 3'b000;
    MemToReg = 2'b00;
    NPCSel   = 2'b00;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
      end
      S_EXEC_R: ALUOp = (cls == C_SUBU) ? 3'b001 : 3'b000;
      S_EXEC_I: begin
        ALUSrc = 1'b1;
        ALUOp  = (cls == C_LUI) ? 3'b011 : 3'b010;
      end
      // Write-back keeps the ALU selects of the EXEC state so the result stays valid.
      S_WB_REG: begin
        RegWrite = 1'b1;
        if (r_type) begin
          RegDst = 2'b01;
          ALUOp  = (cls == C_SUBU) ? 3'b001 : 3'b000;
        end else begin
          ALUSrc = 1'b1;
          ALUOp  = (cls == C_LUI) ? 3'b011 : 3'b010;
        end
      end
      S_MEM_ADDR, S_MEM_RD: begin
        ALUSrc = 1'b1;
        ExtOp  = 1'b1;
      end
      S_MEM_WR: begin
        ALUSrc   = 1'b1;
        ExtOp    = 1'b1;
        MemWrite = 1'b1;
      end
      S_WB_MEM: begin
        RegWrite = 1'b1;
        MemToReg = 2'b01;
      end
      // Zero reaches PCWrite combinationally only here.
      S_BRANCH: begin
        ALUOp   = 3'b001;
        ExtOp   = 1'b1;
        NPCSel  = 2'b01;
        PCWrite = Zero;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        if (cls == C_JAL) begin
          NPCSel   = 2'b10;
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemToReg = 2'b10;
        end else begin
          NPCSel = 2'b11;
        end
      end
      default: ;
    endcase
  end

  assign State   = state_q;
  assign Illegal = (state_q == S_DECODE) && (cls == C_ILL);
  assign RetCnt  = ret_cnt_q;

endmodule
